// File: rtl/pwm_pkg.sv
// Shared PWM types: counter/channel widths, config record and generator state.
// Pure declarations with no latency and no flow control.
// Imported by every PWM generator file; optional macro PWM_SOFT_STOP_EN is consumed by the generator.
package pwm_pkg;

    localparam int PWM_CNT_W = 28;
    localparam int PWM_CH_W  = 8;

    typedef struct packed {
        logic                 en;
        logic [PWM_CNT_W-1:0] period;
        logic [PWM_CNT_W-1:0] hlevel;
    } pwm_cfg_t;

    typedef enum logic {
        PWM_IDLE = 1'b0,
        PWM_RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_channel_gen_if.sv
// Broadcast PWM config bus: one-cycle strobe carrying channel index and parameters.
// No latency; fire-and-forget strobe with no backpressure path.
// The parser side drives through master and each channel listens through slave.
interface pwm_channel_gen_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
);
    logic                pwm_config_vld;
    logic [PWM_CH_W-1:0] pwm_config_channel;
    logic                pwm_en;
    logic [CNT_W-1:0]    pwm_period;
    logic [CNT_W-1:0]    pwm_hlevel;

    modport master (
        output pwm_config_vld,
        output pwm_config_channel,
        output pwm_en,
        output pwm_period,
        output pwm_hlevel
    );

    modport slave (
        input pwm_config_vld,
        input pwm_config_channel,
        input pwm_en,
        input pwm_period,
        input pwm_hlevel
    );
endinterface

// File: rtl/pwm_channel_gen.sv
// Per-channel PWM generator with double-buffered parameters switched at period boundaries.
// Latency: strobe in cycle N -> first output sample in N+2; outputs are registered.
// No backpressure; macro PWM_SOFT_STOP_EN makes a disable wait for the period to finish.
module pwm_channel_gen
    import pwm_pkg::*;
#(
    parameter int   CHANNEL_ID = 0,
    parameter int   CNT_W      = PWM_CNT_W,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    pwm_channel_gen_if.slave   cfg,
    output logic               pwm_out,
    output logic               pwm_active,
    output logic               period_start,
    output logic               cfg_err
);

    localparam logic [PWM_CH_W-1:0] CH_ID = PWM_CH_W'(CHANNEL_ID);

    typedef struct packed {
        logic             en;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] hlevel;
    } cfg_t;

    pwm_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    cfg_t             act, act_nx;
    cfg_t             pend_cfg, pend_cfg_nx;
    logic             pend, pend_nx;
    cfg_t             in_cfg;
    logic             accept, bad_cfg, run, wrap;
    logic             pwm_out_nx, active_nx, start_nx, err_nx;

    always_comb begin
        accept = cfg.pwm_config_vld && (cfg.pwm_config_channel == CH_ID);
        // A zero period can never run, so it is stored as a disable.
        in_cfg.en     = cfg.pwm_en && (cfg.pwm_period != '0);
        in_cfg.period = cfg.pwm_period;
        in_cfg.hlevel = cfg.pwm_hlevel;
        bad_cfg       = accept && cfg.pwm_en && (cfg.pwm_period == '0);
        run           = (state == PWM_RUN);
        wrap          = run && (cnt == act.period - CNT_W'(1));
    end

    always_comb begin
        cnt_nx      = cnt;
        act_nx      = act;
        pend_cfg_nx = pend_cfg;
        pend_nx     = pend;

        if (!run) begin
            cnt_nx = '0;
            if (accept) begin
                act_nx  = in_cfg;
                pend_nx = 1'b0;
            end
        end else begin
            cnt_nx = wrap ? '0 : cnt + CNT_W'(1);
            if (wrap) begin
                if (accept) begin
                    act_nx  = in_cfg;
                    pend_nx = 1'b0;
                end else if (pend) begin
                    act_nx  = pend_cfg;
                    pend_nx = 1'b0;
                end
            end else if (accept) begin
`ifdef PWM_SOFT_STOP_EN
                pend_cfg_nx = in_cfg;
                pend_nx     = 1'b1;
`else
                if (!in_cfg.en) begin
                    act_nx  = in_cfg;
                    pend_nx = 1'b0;
                    cnt_nx  = '0;
                end else begin
                    pend_cfg_nx = in_cfg;
                    pend_nx     = 1'b1;
                end
`endif
            end
        end

        state_nx   = act_nx.en ? PWM_RUN : PWM_IDLE;
        pwm_out_nx = (run && (cnt < act.hlevel)) ? ~IDLE_LEVEL : IDLE_LEVEL;
        active_nx  = run;
        start_nx   = run && (cnt == '0);
        err_nx     = bad_cfg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PWM_IDLE;
            cnt          <= '0;
            act          <= '0;
            pend_cfg     <= '0;
            pend         <= 1'b0;
            pwm_out      <= IDLE_LEVEL;
            pwm_active   <= 1'b0;
            period_start <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            act          <= act_nx;
            pend_cfg     <= pend_cfg_nx;
            pend         <= pend_nx;
            pwm_out      <= pwm_out_nx;
            pwm_active   <= active_nx;
            period_start <= start_nx;
            cfg_err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_pwm_channel_gen.sv
// Scoreboard bench for pwm_channel_gen (CHANNEL_ID=3): expected per-cycle outputs are queued with the
// cycle they must appear in, and a negedge monitor pops and compares; PWM_SOFT_STOP_EN selects the disable timing.
module tb_pwm_channel_gen;
    import pwm_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] val;  // {pwm_out, pwm_active, period_start, cfg_err}
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    logic pwm_out, pwm_active, period_start, cfg_err;
    int   cyc;
    int   ecyc;
    int   tests;
    int   fails;
    exp_t q[$];

    pwm_channel_gen_if #(.CNT_W(PWM_CNT_W)) cfg_if ();

    pwm_channel_gen #(
        .CHANNEL_ID(3),
        .CNT_W     (PWM_CNT_W),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_if),
        .pwm_out     (pwm_out),
        .pwm_active  (pwm_active),
        .period_start(period_start),
        .cfg_err     (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [3:0] act_v;
            e     = q.pop_front();
            act_v = {pwm_out, pwm_active, period_start, cfg_err};
            tests++;
            if (e.cyc != cyc || act_v !== e.val) begin
                fails++;
                $display("FAIL %s cyc=%0d: got out/act/start/err=%b required %b (due cyc %0d)",
                         e.name, cyc, act_v, e.val, e.cyc);
            end
        end
    end

    task automatic push(input logic [3:0] v, input string name);
        exp_t e;
        e.cyc  = ecyc;
        e.val  = v;
        e.name = name;
        q.push_back(e);
        ecyc++;
    endtask

    task automatic push_idle(input int n, input string name);
        for (int i = 0; i < n; i++) push(4'b0000, name);
    endtask

    // Hand-parameterised steady waveform: output shows counter phase ph, ph+1, ...
    task automatic push_run(input int p, input int h, input int n, input int ph, input string name);
        for (int i = 0; i < n; i++) begin
            int c;
            c = (ph + i) % p;
            push({(c < h), 1'b1, (c == 0), 1'b0}, name);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int ch, input logic en, input int p, input int h);
        cfg_if.pwm_config_vld     = 1'b1;
        cfg_if.pwm_config_channel = PWM_CH_W'(ch);
        cfg_if.pwm_en             = en;
        cfg_if.pwm_period         = PWM_CNT_W'(p);
        cfg_if.pwm_hlevel         = PWM_CNT_W'(h);
        goto(cyc + 1);
        cfg_if.pwm_config_vld     = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ecyc  = 1;
        rst   = 1'b1;
        cfg_if.pwm_config_vld     = 1'b0;
        cfg_if.pwm_config_channel = '0;
        cfg_if.pwm_en             = 1'b0;
        cfg_if.pwm_period         = '0;
        cfg_if.pwm_hlevel         = '0;
        push_idle(9, "reset_idle");

        goto(3);
        rst = 1'b0;
        goto(5);
        strobe(5, 1'b1, 4, 2);

        goto(10);
        push_idle(2, "start_latency");
        push_run(10, 3, 30, 0, "run_10_3");
        strobe(3, 1'b1, 10, 3);

        goto(36);
        push_run(20, 5, 20, 0, "run_20_5_after_wrap");
        strobe(3, 1'b1, 20, 5);

        goto(45);
        push_run(10, 12, 10, 0, "hlevel_ge_period");
        strobe(3, 1'b1, 10, 12);

        goto(50);
        strobe(5, 1'b0, 4, 1);

        goto(66);
        push_run(10, 0, 14, 0, "hlevel_zero");
        strobe(3, 1'b1, 10, 0);

        goto(85);
`ifdef PWM_SOFT_STOP_EN
        push_run(10, 0, 6, 4, "soft_stop_tail");
`else
        push_run(10, 0, 1, 4, "hard_stop_tail");
`endif
        push_idle(100 - ecyc, "disabled_idle");
        strobe(3, 1'b0, 10, 3);

        goto(100);
        push_idle(1, "zero_period_pre");
        push(4'b0001, "cfg_err_pulse");
        push_idle(8, "zero_period_idle");
        strobe(3, 1'b1, 0, 3);

        goto(110);
        push_idle(2, "restart_latency");
        push_run(10, 3, 5, 0, "run_before_rst");
        push_idle(10, "after_rst");
        strobe(3, 1'b1, 10, 3);

        goto(116);
        rst = 1'b1;
        goto(117);
        rst = 1'b0;

        goto(ecyc + 2);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected entries never compared, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_channel_gen.md
Name: pwm_channel_gen

Overview:
- Per-channel PWM waveform generator. Consumes the broadcast config bus from the PWM parameter-parsing stage (channel index, enable, period count, high-level count) and drives one PWM pin.
- Instantiated N times at top level, one per output, each with a distinct CHANNEL_ID.
- Double-buffers parameters so a new setting takes effect glitch-free at a period boundary.

Parameters:
- CHANNEL_ID, 0, channel index this instance responds to (8-bit compare).
- CNT_W, 28, width of period/hlevel/counter.
- IDLE_LEVEL, 0, pwm_out value while disabled/reset.

Ports:
- clk  input  1  module clock
- rst  input  1  synchronous reset, active-high
- pwm_config_vld  input  1  single-cycle config strobe
- pwm_config_channel  input  8  target channel index
- pwm_en  input  1  output enable
- pwm_period  input  CNT_W  clocks per PWM period
- pwm_hlevel  input  CNT_W  clocks of high level per period
- pwm_out  output  1  registered PWM waveform
- pwm_active  output  1  1 while the generator is running
- period_start  output  1  one-cycle pulse in the cycle pwm_out shows counter value 0
- cfg_err  output  1  one-cycle pulse: accepted config had en=1 and period=0

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - pwm_out=IDLE_LEVEL; pwm_active=0; period_start=0; cfg_err=0.
  - Counter, active regs and pending regs cleared; pend=0.
  - Reset mid-period aborts immediately.
- Accept: pwm_config_vld=1 and pwm_config_channel==CHANNEL_ID[7:0]. Non-matching strobes are ignored entirely.
- Register sets:
  - Pending regs (en, period, hlevel, pend flag). Last write wins; pend is set on accept.
  - Active regs (act_en, act_period, act_hlevel).
- Normalisation at accept: en=1 with period=0 is stored as en=0, and cfg_err pulses the next cycle.
- State IDLE (act_en=0):
  - cnt=0; pwm_out=IDLE_LEVEL; pwm_active=0.
  - An accept in cycle N loads the active regs directly at the N edge; pend stays 0.
  - If en=1: RUN from N+1 with cnt=0. pwm_active=1, period_start=1 and the first pwm_out sample all appear in N+2 (one output register stage).
- State RUN (act_en=1):
  - cnt increments each cycle; wraps to 0 when cnt==act_period-1.
  - pwm_out <= (cnt < act_hlevel) ? ~IDLE_LEVEL : IDLE_LEVEL.
  - hlevel=0 gives constant inactive; hlevel>=period gives constant active.
  - period_start <= (cnt==0).
- Update in RUN: at the wrap edge, if pend=1, copy pending to active and clear pend. The new period begins at cnt=0 with the new values. If new en=0, go to IDLE.
- Accept coincident with wrap: the incoming values load into active directly (bypass pending); pend is cleared.
- Accept in RUN with en=0 (macro off): applied immediately at the accept edge. IDLE from N+1; pwm_out=IDLE_LEVEL from N+2; pend cleared.
- Arithmetic: cnt is CNT_W unsigned. act_period-1 is computed only when act_period≥1, which normalisation guarantees.

Optional Feature:
- Macro: PWM_SOFT_STOP_EN.
- Defined: a disable request in RUN is held in the pending regs like any other update. The current period completes, and the block goes to IDLE at the wrap. pwm_active drops one cycle after that edge.
- Undefined: a disable takes effect immediately, as above.

Decomposition:
- Shared package pwm_pkg:
  - PWM_CNT_W=28 and PWM_CH_W=8.
  - typedef pwm_cfg_t {en, period, hlevel}.
  - State enum {PWM_IDLE, PWM_RUN}.
- No sub-module is needed. The counter/compare logic is small enough to stay inline.

Test Plan:
- CHANNEL_ID=3; accept ch3, en=1, period=10, hlevel=3 → period_start every 10 cycles; pwm_out high 3 / low 7; first high sample 2 cycles after the strobe.
- While running 10/3, at mid-period send ch3 period=20, hlevel=5 → current period ends unchanged; next period_start begins 5 high / 15 low.
- Strobe to ch5 with en=1, period=4 → no change to any output.
- period=10, hlevel=12, then hlevel=0 → constant high for a full period, then constant low after the boundary; period_start still toggles every 10 cycles.
- Accept en=1, period=0 → cfg_err single pulse; pwm_active stays 0; pwm_out=IDLE_LEVEL.
- Disable mid-period, then rst mid-period → macro off: idle 2 cycles after the strobe; macro on: idle after the wrap. rst: all outputs at reset values the cycle after the rst edge.
